// File: rtl/fog_lut_intensity_pkg.sv
// Shared definitions for the fog intensity LUT: config word layout, default
// sizes, config FSM encoding and the output clamp.
package fog_lut_intensity_pkg;

    localparam int DEPTH_WIDTH_DEF   = 24;
    localparam int LUT_SIZE_LOG2_DEF = 5;

    localparam int CFG_FIELD_W = 16;
    localparam int CFG_B_LSB   = 16;
    localparam int CFG_M_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_DISCARD = 2'd2
    } cfg_state_t;

    function automatic logic [CFG_FIELD_W-1:0] cfg_base(input logic [31:0] word);
        return word[CFG_B_LSB +: CFG_FIELD_W];
    endfunction

    function automatic logic signed [CFG_FIELD_W-1:0] cfg_slope(input logic [31:0] word);
        return $signed(word[CFG_M_LSB +: CFG_FIELD_W]);
    endfunction

    function automatic logic [15:0] clamp_u16(input logic signed [17:0] sum);
        if (sum[17])
            return 16'h0000;
        else if (sum[16])
            return 16'hFFFF;
        else
            return sum[15:0];
    endfunction

endpackage

// File: rtl/fog_lut_bank_ram.sv
// Two-bank LUT storage: one write port into the shadow bank, one registered
// read port from the active bank. Contents are not reset.
module fog_lut_bank_ram #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic              wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**(ADDR_W+1)];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[{wr_bank, wr_addr}] <= wr_data;
        rd_data <= mem[{rd_bank, rd_addr}];
    end

endmodule

// File: rtl/fog_lut_intensity.sv
// Depth -> fog intensity through a double-buffered piecewise-linear LUT,
// 4-stage pipeline, table loaded over a stream and swapped atomically.
//
// state      | meaning
// ST_IDLE    | waiting for the first word of a load (always written at index 0)
// ST_LOAD    | writing words into the shadow bank at an incrementing index
// ST_DISCARD | load overran the table; dropping words until tlast
module fog_lut_intensity
    import fog_lut_intensity_pkg::*;
#(
    parameter int DEPTH_WIDTH   = DEPTH_WIDTH_DEF,
    parameter int LUT_SIZE_LOG2 = LUT_SIZE_LOG2_DEF
) (
    input  logic                   aclk,
    input  logic                   resetn,
    input  logic                   s_cfg_tvalid,
    output logic                   s_cfg_tready,
    input  logic                   s_cfg_tlast,
    input  logic [31:0]            s_cfg_tdata,
    input  logic                   depth_valid,
    input  logic [DEPTH_WIDTH-1:0] depth,
    output logic                   intensity_valid,
    output logic [15:0]            intensity,
    output logic                   lut_loaded,
    output logic                   cfg_error
);

    localparam int FRAC_WIDTH = DEPTH_WIDTH - LUT_SIZE_LOG2;
    localparam int LUT_DEPTH  = 1 << LUT_SIZE_LOG2;
    localparam int CNT_W      = LUT_SIZE_LOG2 + 1;
    localparam int PROD_W     = CFG_FIELD_W + FRAC_WIDTH + 1;

    cfg_state_t state, state_nxt;
    logic [CNT_W-1:0] wr_cnt, word_idx;
    logic cfg_fire, overflow, at_last;
    logic wr_en, swap, set_err, clr_err;
    logic bank_sel;

    assign cfg_fire = s_cfg_tvalid & s_cfg_tready;
    assign word_idx = (state == ST_IDLE) ? '0 : wr_cnt;
    assign overflow = word_idx[LUT_SIZE_LOG2];
    assign at_last  = (word_idx == CNT_W'(LUT_DEPTH - 1));

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cfg_fire) begin
            unique case (state)
                ST_IDLE, ST_LOAD: begin
                    if (s_cfg_tlast)
                        state_nxt = ST_IDLE;
                    else if (overflow)
                        state_nxt = ST_DISCARD;
                    else
                        state_nxt = ST_LOAD;
                end
                ST_DISCARD: if (s_cfg_tlast) state_nxt = ST_IDLE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_en   = cfg_fire && (state != ST_DISCARD) && !overflow;
        swap    = wr_en && s_cfg_tlast && at_last;
        set_err = cfg_fire && s_cfg_tlast && !swap;
        clr_err = cfg_fire && (state == ST_IDLE);
    end

    // An error on the very first word wins over the clear of the same word.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            s_cfg_tready <= 1'b0;
            wr_cnt       <= '0;
            bank_sel     <= 1'b0;
            lut_loaded   <= 1'b0;
            cfg_error    <= 1'b0;
        end else begin
            s_cfg_tready <= 1'b1;
            if (wr_en)
                wr_cnt <= word_idx + 1'b1;
            if (swap) begin
                bank_sel   <= ~bank_sel;
                lut_loaded <= 1'b1;
            end
            if (set_err)
                cfg_error <= 1'b1;
            else if (clr_err)
                cfg_error <= 1'b0;
        end
    end

    logic                     v1, v2, v3, ld1, ld2, ld3, bank1;
    logic [LUT_SIZE_LOG2-1:0] idx1;
    logic [FRAC_WIDTH-1:0]    frac1, frac2;
    logic [31:0]              rd_data;
    logic [15:0]              b3;
    logic signed [17:0]       delta3;
    logic signed [PROD_W-1:0] m_ext, f_ext, prod, prod_shr;

    fog_lut_bank_ram #(
        .ADDR_W (LUT_SIZE_LOG2),
        .DATA_W (32)
    ) u_ram (
        .clk     (aclk),
        .wr_en   (wr_en),
        .wr_bank (~bank_sel),
        .wr_addr (word_idx[LUT_SIZE_LOG2-1:0]),
        .wr_data (s_cfg_tdata),
        .rd_bank (bank1),
        .rd_addr (idx1),
        .rd_data (rd_data)
    );

    assign m_ext    = PROD_W'(cfg_slope(rd_data));
    assign f_ext    = PROD_W'($signed({1'b0, frac2}));
    assign prod     = m_ext * f_ext;
    assign prod_shr = prod >>> FRAC_WIDTH;

    // The loaded flag travels with the bank so a fragment sees one consistent table.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
            ld1 <= 1'b0; ld2 <= 1'b0; ld3 <= 1'b0;
            bank1 <= 1'b0;
            idx1 <= '0;
            frac1 <= '0;
            frac2 <= '0;
            b3 <= '0;
            delta3 <= '0;
            intensity_valid <= 1'b0;
            intensity <= 16'hFFFF;
        end else begin
            v1    <= depth_valid;
            idx1  <= depth[DEPTH_WIDTH-1 -: LUT_SIZE_LOG2];
            frac1 <= depth[FRAC_WIDTH-1:0];
            bank1 <= bank_sel;
            ld1   <= lut_loaded;

            v2    <= v1;
            ld2   <= ld1;
            frac2 <= frac1;

            v3     <= v2;
            ld3    <= ld2;
            b3     <= cfg_base(rd_data);
            delta3 <= 18'(prod_shr);

            intensity_valid <= v3;
            if (v3)
                intensity <= ld3 ? clamp_u16($signed({2'b00, b3}) + delta3) : 16'hFFFF;
        end
    end

endmodule

// File: tb/tb_fog_lut_intensity.sv
// Directed bench for fog_lut_intensity: reset, table loads, clamps, malformed
// loads, swap boundary under streaming traffic and reset mid-load.
module tb_fog_lut_intensity;

    logic        aclk = 1'b0;
    logic        resetn;
    logic        s_cfg_tvalid;
    logic        s_cfg_tready;
    logic        s_cfg_tlast;
    logic [31:0] s_cfg_tdata;
    logic        depth_valid;
    logic [23:0] depth;
    logic        intensity_valid;
    logic [15:0] intensity;
    logic        lut_loaded;
    logic        cfg_error;

    int checks = 0;
    int errors = 0;
    logic [15:0] got[$];
    logic [15:0] exp_stream[7];

    always #5 aclk = ~aclk;

    fog_lut_intensity dut (
        .aclk            (aclk),
        .resetn          (resetn),
        .s_cfg_tvalid    (s_cfg_tvalid),
        .s_cfg_tready    (s_cfg_tready),
        .s_cfg_tlast     (s_cfg_tlast),
        .s_cfg_tdata     (s_cfg_tdata),
        .depth_valid     (depth_valid),
        .depth           (depth),
        .intensity_valid (intensity_valid),
        .intensity       (intensity),
        .lut_loaded      (lut_loaded),
        .cfg_error       (cfg_error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cfg_word(input logic [31:0] d, input logic l);
        @(negedge aclk);
        s_cfg_tvalid = 1'b1;
        s_cfg_tdata  = d;
        s_cfg_tlast  = l;
    endtask

    task automatic cfg_idle();
        @(negedge aclk);
        s_cfg_tvalid = 1'b0;
        s_cfg_tlast  = 1'b0;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 32; i++)
            cfg_word({16'(i * 16'h0800), 16'h0000}, i == 31);
        cfg_idle();
    endtask

    task automatic load_entry0(input logic [15:0] b, input logic [15:0] m);
        cfg_word({b, m}, 1'b0);
        for (int i = 1; i < 32; i++)
            cfg_word(32'h0000_0000, i == 31);
        cfg_idle();
    endtask

    task automatic eval(input string tag, input logic [23:0] d, input logic [15:0] exp);
        @(negedge aclk);
        depth_valid = 1'b1;
        depth       = d;
        @(negedge aclk);
        depth_valid = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        check({tag, "_early"}, {31'd0, intensity_valid}, 32'd0);
        @(negedge aclk);
        check({tag, "_valid"}, {31'd0, intensity_valid}, 32'd1);
        check(tag, {16'd0, intensity}, {16'd0, exp});
    endtask

    initial begin
        resetn       = 1'b0;
        s_cfg_tvalid = 1'b0;
        s_cfg_tlast  = 1'b0;
        s_cfg_tdata  = '0;
        depth_valid  = 1'b0;
        depth        = '0;

        #22;
        check("rst_tready", {31'd0, s_cfg_tready}, 32'd0);
        check("rst_ivalid", {31'd0, intensity_valid}, 32'd0);
        check("rst_intensity", {16'd0, intensity}, 32'h0000_FFFF);
        check("rst_loaded", {31'd0, lut_loaded}, 32'd0);
        check("rst_cfg_error", {31'd0, cfg_error}, 32'd0);
        @(negedge aclk);
        resetn = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        check("tready_up", {31'd0, s_cfg_tready}, 32'd1);

        eval("no_table", 24'h123456, 16'hFFFF);
        check("no_table_loaded", {31'd0, lut_loaded}, 32'd0);

        load_ramp();
        check("ramp_loaded", {31'd0, lut_loaded}, 32'd1);
        check("ramp_err", {31'd0, cfg_error}, 32'd0);
        eval("ramp_idx3", 24'h180000, 16'h1800);
        eval("ramp_idx31", 24'hF80000, 16'hF800);

        load_entry0(16'h1000, 16'h4000);
        eval("slope_pos", 24'h040000, 16'h3000);
        load_entry0(16'hF000, 16'h7FFF);
        eval("clamp_hi", 24'h07FFFF, 16'hFFFF);
        load_entry0(16'h0100, 16'h8000);
        eval("clamp_lo", 24'h040000, 16'h0000);

        load_ramp();
        // Short load: tlast on word index 10.
        for (int i = 0; i <= 10; i++)
            cfg_word(32'hFFFF_0000, i == 10);
        cfg_idle();
        check("short_err", {31'd0, cfg_error}, 32'd1);
        check("short_loaded", {31'd0, lut_loaded}, 32'd1);
        eval("short_keep", 24'h180000, 16'h1800);

        // Overlong load: 40 words, tlast on the 40th.
        cfg_word(32'hFFFF_0000, 1'b0);
        @(negedge aclk);
        s_cfg_tvalid = 1'b0;
        check("first_word_clr", {31'd0, cfg_error}, 32'd0);
        for (int i = 1; i < 40; i++)
            cfg_word(32'hFFFF_0000, i == 39);
        cfg_idle();
        check("long_err", {31'd0, cfg_error}, 32'd1);
        eval("long_keep", 24'h180000, 16'h1800);

        // Stream depth every cycle while a new table's load completes.
        for (int k = 0; k < 44; k++) begin
            @(negedge aclk);
            if (intensity_valid)
                got.push_back(intensity);
            s_cfg_tvalid = (k < 32);
            s_cfg_tdata  = {16'(k * 16'h0400 + 16'h0010), 16'h0000};
            s_cfg_tlast  = (k == 31);
            depth_valid  = (k >= 28 && k < 35);
            depth        = 24'h180000;
        end
        s_cfg_tvalid = 1'b0;
        s_cfg_tlast  = 1'b0;
        depth_valid  = 1'b0;
        exp_stream = '{16'h1800, 16'h1800, 16'h1800, 16'h1800, 16'h0C10, 16'h0C10, 16'h0C10};
        check("swap_count", got.size(), 32'd7);
        for (int i = 0; i < 7; i++)
            check($sformatf("swap_frag%0d", i),
                  (i < got.size()) ? {16'd0, got[i]} : 32'hDEAD_BEEF,
                  {16'd0, exp_stream[i]});
        check("swap_err", {31'd0, cfg_error}, 32'd0);

        // Reset mid-load at word 15.
        for (int i = 0; i < 15; i++)
            cfg_word(32'h1234_0000, 1'b0);
        @(negedge aclk);
        s_cfg_tvalid = 1'b0;
        resetn = 1'b0;
        #1;
        check("mid_rst_tready", {31'd0, s_cfg_tready}, 32'd0);
        check("mid_rst_loaded", {31'd0, lut_loaded}, 32'd0);
        check("mid_rst_intensity", {16'd0, intensity}, 32'h0000_FFFF);
        check("mid_rst_ivalid", {31'd0, intensity_valid}, 32'd0);
        check("mid_rst_err", {31'd0, cfg_error}, 32'd0);
        @(negedge aclk);
        @(negedge aclk);
        resetn = 1'b1;
        @(negedge aclk);
        eval("post_rst_unloaded", 24'h180000, 16'hFFFF);
        load_ramp();
        check("post_rst_loaded", {31'd0, lut_loaded}, 32'd1);
        check("post_rst_err", {31'd0, cfg_error}, 32'd0);
        eval("post_rst_ramp", 24'h180000, 16'h1800);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
